tb_axi_cmd_initiator: RTL and testbench

// Single-outstanding AXI4 initiator that turns a simple valid/ready command stream
// (read/write, addr, data, strb) into one-beat AXI transactions.
// It returns the B/R result on a response stream.

---
 rtl/tb_axi_cmd_initiator.sv | 279 +++++++++++++++++++++++++++
 tb/tb_tb_axi_cmd_initiator.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_axi_cmd_initiator.sv
// tb_axi_cmd_initiator: single-outstanding AXI4 initiator used by the testharness.
// Turns a valid/ready command stream into one-beat AXI reads/writes, returns the
// B/R result on a response stream and keeps completion/error counters.

package tb_axi_cmd_initiator_pkg;

  localparam int unsigned AxiAddrWidth = 48;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 8;
  localparam int unsigned AxiUserWidth = 1;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [5:0]              atop;
    logic [AxiUserWidth-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [AxiUserWidth-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

endpackage

module tb_axi_cmd_initiator #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned UserWidth = 1,
  parameter type req_t = tb_axi_cmd_initiator_pkg::axi_req_t,
  parameter type rsp_t = tb_axi_cmd_initiator_pkg::axi_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  input  logic [DataWidth/8-1:0] cmd_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic [1:0]             rsp_resp_o,
  output logic [15:0]            rsp_latency_o,
  output logic [31:0]            txn_count_o,
  output logic [31:0]            err_count_o,
  output req_t                   axi_req_o,
  input  rsp_t                   axi_rsp_i
);

  localparam int unsigned    StrbWidth = DataWidth / 8;
  localparam logic [2:0]     AxiSize   = 3'($clog2(StrbWidth));
  localparam logic [1:0]     BurstIncr = 2'b01;
  localparam logic [IdWidth-1:0]   IdZero   = '0;
  localparam logic [UserWidth-1:0] UserZero = '0;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_A,
    WAIT_B,
    WAIT_R,
    RESP
  } state_e;

  state_e                 r_state;
  logic [AddrWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_wdata;
  logic [StrbWidth-1:0]   r_strb;
  logic                   r_aw_done;
  logic                   r_w_done;
  logic [15:0]            r_cnt;
  logic                   r_rsp_valid;
  logic [DataWidth-1:0]   r_rsp_rdata;
  logic [1:0]             r_rsp_resp;
  logic [15:0]            r_rsp_latency;
  logic [31:0]            r_txn_count;
  logic [31:0]            r_err_count;

  logic                   w_aw_valid;
  logic                   w_w_valid;
  logic                   w_aw_done_nxt;
  logic                   w_w_done_nxt;
  logic [15:0]            w_cnt_sat;
  logic                   w_unused;

  assign cmd_ready_o   = (r_state == IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_resp_o    = r_rsp_resp;
  assign rsp_latency_o = r_rsp_latency;
  assign txn_count_o   = r_txn_count;
  assign err_count_o   = r_err_count;

  // AW and W each stay valid until their own handshake has been seen.
  assign w_aw_valid    = (r_state == WRITE) && !r_aw_done;
  assign w_w_valid     = (r_state == WRITE) && !r_w_done;
  assign w_aw_done_nxt = r_aw_done || (w_aw_valid && axi_rsp_i.aw_ready);
  assign w_w_done_nxt  = r_w_done  || (w_w_valid  && axi_rsp_i.w_ready);

  // One saturating step serves both the running count and the reported latency.
  assign w_cnt_sat = (r_cnt == 16'hFFFF) ? 16'hFFFF : r_cnt + 16'd1;

  // IDs, r.last and user fields are irrelevant with a single outstanding transaction.
  assign w_unused = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id,
                      axi_rsp_i.r.last, axi_rsp_i.r.user};

  // Drive the AXI request from the registered command and the current state.
  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw.id     = IdZero;
    axi_req_o.aw.addr   = r_addr;
    axi_req_o.aw.len    = '0;
    axi_req_o.aw.size   = AxiSize;
    axi_req_o.aw.burst  = BurstIncr;
    axi_req_o.aw.user   = UserZero;
    axi_req_o.aw_valid  = w_aw_valid;
    axi_req_o.w.data    = r_wdata;
    axi_req_o.w.strb    = r_strb;
    axi_req_o.w.last    = 1'b1;
    axi_req_o.w.user    = UserZero;
    axi_req_o.w_valid   = w_w_valid;
    axi_req_o.b_ready   = (r_state == WAIT_B);
    axi_req_o.ar.id     = IdZero;
    axi_req_o.ar.addr   = r_addr;
    axi_req_o.ar.len    = '0;
    axi_req_o.ar.size   = AxiSize;
    axi_req_o.ar.burst  = BurstIncr;
    axi_req_o.ar.user   = UserZero;
    axi_req_o.ar_valid  = (r_state == READ_A);
    axi_req_o.r_ready   = (r_state == WAIT_R);
  end

  // Command FSM: accept, run one AXI transaction, hold the result until consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_strb        <= '0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_rsp_latency <= '0;
      r_txn_count   <= '0;
      r_err_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_addr    <= cmd_addr_i;
            r_wdata   <= cmd_wdata_i;
            r_strb    <= cmd_strb_i;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_cnt     <= '0;
            r_state   <= cmd_write_i ? WRITE : READ_A;
          end
        end
        WRITE: begin
          r_cnt     <= w_cnt_sat;
          r_aw_done <= w_aw_done_nxt;
          r_w_done  <= w_w_done_nxt;
          if (w_aw_done_nxt && w_w_done_nxt) begin
            r_state <= WAIT_B;
          end
        end
        READ_A: begin
          r_cnt <= w_cnt_sat;
          if (axi_rsp_i.ar_ready) begin
            r_state <= WAIT_R;
          end
        end
        WAIT_B: begin
          r_cnt <= w_cnt_sat;
          if (axi_rsp_i.b_valid) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= axi_rsp_i.b.resp;
            r_rsp_latency <= w_cnt_sat;
            r_txn_count   <= r_txn_count + 32'd1;
            if (axi_rsp_i.b.resp != 2'b00) begin
              r_err_count <= r_err_count + 32'd1;
            end
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end
        end
        WAIT_R: begin
          r_cnt <= w_cnt_sat;
          if (axi_rsp_i.r_valid) begin
            r_rsp_rdata   <= axi_rsp_i.r.data;
            r_rsp_resp    <= axi_rsp_i.r.resp;
            r_rsp_latency <= w_cnt_sat;
            r_txn_count   <= r_txn_count + 32'd1;
            if (axi_rsp_i.r.resp != 2'b00) begin
              r_err_count <= r_err_count + 32'd1;
            end
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_axi_cmd_initiator.sv
// Self-checking bench for tb_axi_cmd_initiator: a configurable one-beat AXI slave
// with memory, directed scenarios and randomized transactions checked against a
// byte-level memory model and interface-measured latencies.
`timescale 1ns/1ps

module tb_tb_axi_cmd_initiator;
  import tb_axi_cmd_initiator_pkg::*;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWrite;
  logic [47:0] cmdAddr;
  logic [63:0] cmdWdata;
  logic [7:0]  cmdStrb;
  logic        rspValid;
  logic        rspReady;
  logic [63:0] rspRdata;
  logic [1:0]  rspResp;
  logic [15:0] rspLatency;
  logic [31:0] txnCount;
  logic [31:0] errCount;
  axi_req_t    axiReq;
  axi_rsp_t    axiRsp;

  int assertCount = 0;
  int failCount   = 0;

  // Slave knobs
  int         awStall = 0;
  int         wStall  = 0;
  int         arStall = 0;
  int         bDelay  = 0;
  int         rDelay  = 0;
  logic [1:0] bRespKnob = 2'b00;
  logic [1:0] rRespKnob = 2'b00;

  // Slave state
  int          awSeen, wSeen, arSeen;
  logic        gotAw, gotW;
  logic [47:0] wrAddr;
  logic [63:0] wrData;
  logic [7:0]  wrStrb;
  logic        bPending, rPending;
  int          bWait, rWait;
  logic [1:0]  bResp, rdResp;
  logic [63:0] rdData;
  logic [63:0] slaveMem [logic [44:0]];
  logic        awReady, wReady, arReady;

  // Bench-side expectations
  logic [63:0] refMem [logic [44:0]];
  int          refTxn = 0;
  int          refErr = 0;
  logic [47:0] curAddr;
  logic [63:0] curWdata;
  logic [7:0]  curStrb;
  logic [63:0] lastRdata;
  logic [1:0]  lastResp;

  // Interface monitor state
  int          cycleCount = 0;
  int          acceptCycle = 0;
  int          hsCycle = 0;
  int          hsCount = 0;
  int          awValidCycles = 0;
  int          wValidCycles = 0;
  logic        wChanged = 1'b0;
  axi_w_chan_t prevW;
  logic        prevWValid = 1'b0;

  tb_axi_cmd_initiator #(
    .AddrWidth(48),
    .DataWidth(64),
    .IdWidth  (8),
    .UserWidth(1),
    .req_t    (axi_req_t),
    .rsp_t    (axi_rsp_t)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .cmd_valid_i  (cmdValid),
    .cmd_ready_o  (cmdReady),
    .cmd_write_i  (cmdWrite),
    .cmd_addr_i   (cmdAddr),
    .cmd_wdata_i  (cmdWdata),
    .cmd_strb_i   (cmdStrb),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_rdata_o  (rspRdata),
    .rsp_resp_o   (rspResp),
    .rsp_latency_o(rspLatency),
    .txn_count_o  (txnCount),
    .err_count_o  (errCount),
    .axi_req_o    (axiReq),
    .axi_rsp_i    (axiRsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
    end
  endtask

  assign awReady = (awSeen >= awStall);
  assign wReady  = (wSeen  >= wStall);
  assign arReady = (arSeen >= arStall);

  // Slave response channels are presented from registered slave state.
  always_comb begin
    axiRsp          = '0;
    axiRsp.aw_ready = awReady;
    axiRsp.w_ready  = wReady;
    axiRsp.ar_ready = arReady;
    axiRsp.b_valid  = bPending && (bWait == 0);
    axiRsp.b.resp   = bResp;
    axiRsp.r_valid  = rPending && (rWait == 0);
    axiRsp.r.data   = rdData;
    axiRsp.r.resp   = rdResp;
    axiRsp.r.last   = 1'b1;
  end

  // Memory-backed AXI slave with programmable ready stalls and response delays.
  always @(posedge clk or negedge rstN) begin : slaveModel
    logic        nGotAw, nGotW;
    logic [47:0] nAddr;
    logic [63:0] nData;
    logic [7:0]  nStrb;
    logic [63:0] word;
    if (!rstN) begin
      awSeen <= 0; wSeen <= 0; arSeen <= 0;
      gotAw <= 1'b0; gotW <= 1'b0;
      wrAddr <= '0; wrData <= '0; wrStrb <= '0;
      bPending <= 1'b0; rPending <= 1'b0;
      bWait <= 0; rWait <= 0;
      bResp <= '0; rdResp <= '0; rdData <= '0;
    end else begin
      nGotAw = gotAw; nGotW = gotW;
      nAddr = wrAddr; nData = wrData; nStrb = wrStrb;
      if (axiReq.aw_valid) begin
        if (awReady) begin
          nGotAw = 1'b1;
          nAddr  = axiReq.aw.addr;
          awSeen <= 0;
          checkOutput("awAddr", 96'(axiReq.aw.addr), 96'(curAddr));
          checkOutput("awAttr",
            96'({axiReq.aw.len, axiReq.aw.size, axiReq.aw.burst, axiReq.aw.lock, axiReq.aw.cache,
                 axiReq.aw.prot, axiReq.aw.qos, axiReq.aw.region, axiReq.aw.atop, axiReq.aw.id, axiReq.aw.user}),
            96'({8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 8'd0, 1'b0}));
        end else begin
          awSeen <= awSeen + 1;
        end
      end
      if (axiReq.w_valid) begin
        if (wReady) begin
          nGotW = 1'b1;
          nData = axiReq.w.data;
          nStrb = axiReq.w.strb;
          wSeen <= 0;
          checkOutput("wPayload", {axiReq.w.last, axiReq.w.user, axiReq.w.strb, axiReq.w.data},
                      {1'b1, 1'b0, curStrb, curWdata});
        end else begin
          wSeen <= wSeen + 1;
        end
      end
      if (nGotAw && nGotW) begin
        word = slaveMem.exists(nAddr[47:3]) ? slaveMem[nAddr[47:3]] : 64'd0;
        for (int i = 0; i < 8; i++) begin
          if (nStrb[i]) word[i*8 +: 8] = nData[i*8 +: 8];
        end
        slaveMem[nAddr[47:3]] = word;
        gotAw <= 1'b0; gotW <= 1'b0;
        bPending <= 1'b1; bWait <= bDelay; bResp <= bRespKnob;
      end else begin
        gotAw <= nGotAw; gotW <= nGotW;
        wrAddr <= nAddr; wrData <= nData; wrStrb <= nStrb;
      end
      if (bPending) begin
        if (bWait != 0) bWait <= bWait - 1;
        else if (axiReq.b_ready) bPending <= 1'b0;
      end
      if (axiReq.ar_valid) begin
        if (arReady) begin
          arSeen <= 0;
          rdData <= slaveMem.exists(axiReq.ar.addr[47:3]) ? slaveMem[axiReq.ar.addr[47:3]] : 64'd0;
          rdResp <= rRespKnob;
          rPending <= 1'b1; rWait <= rDelay;
          checkOutput("arAddr", 96'(axiReq.ar.addr), 96'(curAddr));
          checkOutput("arAttr",
            96'({axiReq.ar.len, axiReq.ar.size, axiReq.ar.burst, axiReq.ar.id, axiReq.ar.user}),
            96'({8'd0, 3'd3, 2'd1, 8'd0, 1'b0}));
        end else begin
          arSeen <= arSeen + 1;
        end
      end
      if (rPending) begin
        if (rWait != 0) rWait <= rWait - 1;
        else if (axiReq.r_ready) rPending <= 1'b0;
      end
    end
  end

  // Observe accepts, handshakes and W-channel behaviour on the interfaces.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
    prevW      <= axiReq.w;
    prevWValid <= axiReq.w_valid;
    if (cmdValid && cmdReady) begin
      acceptCycle   <= cycleCount;
      awValidCycles <= 0;
      wValidCycles  <= 0;
      wChanged      <= 1'b0;
      hsCount       <= 0;
    end else begin
      if (axiReq.aw_valid) awValidCycles <= awValidCycles + 1;
      if (axiReq.w_valid)  wValidCycles  <= wValidCycles + 1;
      if (axiReq.w_valid && prevWValid && (axiReq.w != prevW)) wChanged <= 1'b1;
      if ((axiReq.b_ready && axiRsp.b_valid) || (axiReq.r_ready && axiRsp.r_valid)) begin
        hsCycle <= cycleCount;
        hsCount <= hsCount + 1;
      end
    end
  end

  // One complete command: accept, await response, hold it rspHold cycles, consume.
  task automatic applyStimulus(input logic isWrite, input logic [47:0] addr, input logic [63:0] data,
                               input logic [7:0] strb, input int rspHold, input int expLatency);
    logic [63:0] expData;
    logic [63:0] word;
    logic [1:0]  expResp;
    int          waitCnt;
    int          latency;
    curAddr = addr; curWdata = data; curStrb = strb;
    @(negedge clk);
    cmdValid = 1'b1; cmdWrite = isWrite; cmdAddr = addr; cmdWdata = data; cmdStrb = strb;
    waitCnt = 0;
    while (!cmdReady && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmdReady) begin
      checkOutput("acceptTimeout", 96'(cmdReady), 96'(1));
      cmdValid = 1'b0;
      return;
    end
    @(negedge clk);
    cmdValid = 1'b0;
    if (isWrite) begin
      word = refMem.exists(addr[47:3]) ? refMem[addr[47:3]] : 64'd0;
      for (int i = 0; i < 8; i++) begin
        if (strb[i]) word[i*8 +: 8] = data[i*8 +: 8];
      end
      refMem[addr[47:3]] = word;
      expData = 64'd0;
      expResp = bRespKnob;
    end else begin
      expData = refMem.exists(addr[47:3]) ? refMem[addr[47:3]] : 64'd0;
      expResp = rRespKnob;
    end
    refTxn++;
    if (expResp != 2'b00) refErr++;
    checkOutput("cmdReadyBusy", 96'(cmdReady), 96'(0));
    waitCnt = 0;
    while (!rspValid && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rspValid) begin
      checkOutput("rspTimeout", 96'(rspValid), 96'(1));
      return;
    end
    latency = (expLatency >= 0) ? expLatency : (hsCycle - acceptCycle);
    lastRdata = rspRdata;
    lastResp  = rspResp;
    checkOutput("rspRdata", 96'(rspRdata), 96'(expData));
    checkOutput("rspResp", 96'(rspResp), 96'(expResp));
    checkOutput("rspLatency", 96'(rspLatency), 96'(latency));
    checkOutput("txnCount", 96'(txnCount), 96'(refTxn));
    checkOutput("errCount", 96'(errCount), 96'(refErr));
    checkOutput("oneHandshake", 96'(hsCount), 96'(1));
    for (int i = 0; i < rspHold; i++) begin
      @(negedge clk);
      checkOutput("rspHeld", {rspValid, cmdReady, rspResp, rspLatency, rspRdata},
                  {1'b1, 1'b0, expResp, 16'(latency), expData});
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("rspDone", 96'({rspValid, cmdReady}), 96'({1'b0, 1'b1}));
  endtask

  // Abort the run if something stops making progress.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized transactions.
  initial begin
    logic        isWr;
    logic [1:0]  pickResp;
    int          pick;
    rstN = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0;
    cmdWdata = '0; cmdStrb = '0; rspReady = 1'b0;
    curAddr = '0; curWdata = '0; curStrb = '0;
    #1;
    checkOutput("resetCtrl", 96'({cmdReady, rspValid, axiReq.aw_valid, axiReq.w_valid,
                                   axiReq.ar_valid, axiReq.b_ready, axiReq.r_ready}),
                96'({1'b1, 6'b000000}));
    checkOutput("resetData", {rspResp, rspLatency, rspRdata}, 96'd0);
    checkOutput("resetCounters", 96'({txnCount, errCount}), 96'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    $display("[TB] write then read back");
    applyStimulus(1'b1, 48'h0000_8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 2);
    applyStimulus(1'b0, 48'h0000_8000_0000, 64'd0, 8'h00, 0, 2);
    checkOutput("t1Data", 96'(lastRdata), 96'(64'hDEAD_BEEF_CAFE_F00D));
    checkOutput("t1Counters", 96'({txnCount, errCount}), 96'({32'd2, 32'd0}));

    $display("[TB] partial strobe write");
    applyStimulus(1'b1, 48'h0000_8000_0000, 64'h1111_1111_1111_1111, 8'h0F, 0, 2);
    applyStimulus(1'b0, 48'h0000_8000_0000, 64'd0, 8'h00, 0, 2);
    checkOutput("t2Data", 96'(lastRdata), 96'(64'hDEAD_BEEF_1111_1111));

    $display("[TB] W channel stalled");
    wStall = 5;
    applyStimulus(1'b1, 48'h0000_8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 7);
    checkOutput("t3AwCycles", 96'(awValidCycles), 96'(1));
    checkOutput("t3WCycles", 96'(wValidCycles), 96'(6));
    checkOutput("t3WStable", 96'(wChanged), 96'(0));
    wStall = 0;

    $display("[TB] response backpressure");
    applyStimulus(1'b0, 48'h0000_8000_0008, 64'd0, 8'h00, 10, 2);
    checkOutput("t5Data", 96'(lastRdata), 96'(64'h0123_4567_89AB_CDEF));

    $display("[TB] read error response after reset");
    @(negedge clk);
    rstN = 1'b0;
    refTxn = 0; refErr = 0;
    @(negedge clk);
    rstN = 1'b1;
    rRespKnob = 2'b10;
    applyStimulus(1'b0, 48'h0000_8000_0000, 64'd0, 8'h00, 0, 2);
    checkOutput("t4Resp", 96'(lastResp), 96'(2));
    checkOutput("t4Counters", 96'({txnCount, errCount}), 96'({32'd1, 32'd1}));
    rRespKnob = 2'b00;

    $display("[TB] reset while waiting for B");
    bDelay = 6;
    curAddr = 48'h0000_8000_0010; curWdata = 64'hA5A5_5A5A_0F0F_F0F0; curStrb = 8'hFF;
    @(negedge clk);
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = curAddr; cmdWdata = curWdata; cmdStrb = curStrb;
    @(negedge clk);
    cmdValid = 1'b0;
    refMem[curAddr[47:3]] = curWdata;
    @(negedge clk);
    checkOutput("t6InWaitB", 96'({axiReq.b_ready, cmdReady}), 96'({1'b1, 1'b0}));
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6AsyncCtrl", 96'({axiReq.b_ready, rspValid, cmdReady, axiReq.aw_valid, axiReq.w_valid}),
                96'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
    checkOutput("t6AsyncCounters", 96'({txnCount, errCount}), 96'd0);
    refTxn = 0; refErr = 0;
    bDelay = 0;
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b1, 48'h0000_8000_0018, 64'h7777_8888_9999_AAAA, 8'hFF, 0, 2);
    applyStimulus(1'b0, 48'h0000_8000_0018, 64'd0, 8'h00, 0, 2);
    checkOutput("t6Data", 96'(lastRdata), 96'(64'h7777_8888_9999_AAAA));

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      isWr    = 1'($urandom_range(0, 1));
      awStall = $urandom_range(0, 3);
      wStall  = $urandom_range(0, 3);
      arStall = $urandom_range(0, 3);
      bDelay  = $urandom_range(0, 3);
      rDelay  = $urandom_range(0, 3);
      pick    = $urandom_range(0, 4);
      pickResp = (pick == 3) ? 2'b10 : ((pick == 4) ? 2'b11 : 2'b00);
      bRespKnob = pickResp;
      rRespKnob = pickResp;
      applyStimulus(isWr, 48'h0000_8000_0100 + 48'(8 * $urandom_range(0, 3)),
                    {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
